// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, FSM states,
// instruction classes and the select encodings driven into the datapath.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StFault} state_t;

  typedef enum logic [3:0] {
    ClsIll, ClsR, ClsI, ClsLw, ClsSw, ClsBr, ClsJal, ClsJalr, ClsLui
  } cls_t;

  // ALU operations; shift direction and slt signedness come from ir[14]/ir[12] in the datapath
  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluAnd   = 3'd2;
  localparam logic [2:0] AluOr    = 3'd3;
  localparam logic [2:0] AluXor   = 3'd4;
  localparam logic [2:0] AluSlt   = 3'd5;
  localparam logic [2:0] AluShift = 3'd6;
  localparam logic [2:0] AluPassB = 3'd7;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmJ = 3'd3;
  localparam logic [2:0] ImmU = 3'd4;

  localparam logic [1:0] ResAlu = 2'd0;
  localparam logic [1:0] ResMem = 2'd1;
  localparam logic [1:0] ResPc4 = 2'd2;

  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcTarget = 2'd1;
  localparam logic [1:0] PcJalr   = 2'd2;

  localparam logic [1:0] SrcAReg   = 2'd0;
  localparam logic [1:0] SrcAPc    = 2'd1;
  localparam logic [1:0] SrcAOldPc = 2'd2;

  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  // Only beq/bne are legal branches
  function automatic cls_t decode_cls(input logic [31:0] instr);
    cls_t c;
    case (instr[6:0])
      OpcR:      c = ClsR;
      OpcI:      c = ClsI;
      OpcLoad:   c = ClsLw;
      OpcStore:  c = ClsSw;
      OpcBranch: c = (instr[14:13] == 2'b00) ? ClsBr : ClsIll;
      OpcJal:    c = ClsJal;
      OpcJalr:   c = ClsJalr;
      OpcLui:    c = ClsLui;
      default:   c = ClsIll;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_sel(input cls_t c);
    logic [2:0] s;
    case (c)
      ClsSw:   s = ImmS;
      ClsBr:   s = ImmB;
      ClsJal:  s = ImmJ;
      ClsLui:  s = ImmU;
      default: s = ImmI;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] alu_op(input logic [31:0] instr, input logic is_r);
    logic [2:0] op;
    case (instr[14:12])
      3'b000:         op = (is_r && instr[30]) ? AluSub : AluAdd;
      3'b001, 3'b101: op = AluShift;
      3'b010, 3'b011: op = AluSlt;
      3'b100:         op = AluXor;
      3'b110:         op = AluOr;
      default:        op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port: one request at a time, held stable until mem_ready.
interface multicycle_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel,
                  input mem_rdata, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel,
                  output mem_rdata, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse when d_i goes 0 -> 1.
module multicycle_ctrl_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic d_q, d_d;

  // Next value of the delayed copy
  always_comb d_d = d_i;

  // Delayed copy of the input
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  // Pulse while input is high but was low last cycle
  always_comb pulse_o = d_i & ~d_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle core control: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared
// memory port, owning IR, retire/cycle counters, run/step gating and sticky fault.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter bit          STEP_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic                eq,
  multicycle_ctrl_if.master   mem,
  output logic [31:0]         ir,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                oldpc_we,
  output logic                ab_we,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_ctrl,
  output logic [2:0]          imm_src,
  output logic [1:0]          result_src,
  output logic                reg_write,
  output logic                retire,
  output logic [XLEN-1:0]     instret,
  output logic [XLEN-1:0]     cycles,
  output logic                fault
);
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] instret_q, instret_d, cycles_q, cycles_d;
  logic [ToW-1:0]  timeout_q, timeout_d;
  logic            issued_q, issued_d;
  logic            step_pulse, fetch_go, req_int, waiting, timeout_hit;
  cls_t            cls;

  multicycle_ctrl_edge_pulse u_step_edge (
    .clk     (clk),
    .rst     (rst),
    .d_i     (step),
    .pulse_o (step_pulse)
  );

  // A fetch, once started, completes even if run drops or the step pulse ends
  assign fetch_go    = issued_q | run | (STEP_EN & step_pulse);
  assign cls         = decode_cls(ir_q);
  assign req_int     = ((state_q == StFetch) & fetch_go) | (state_q == StMem);
  assign waiting     = req_int & ~mem.mem_ready;
  assign timeout_hit = waiting & (timeout_q == ToW'(TIMEOUT - 1));

  // State, IR, counters, timeout and issue latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      instret_q <= '0;
      cycles_q  <= '0;
      timeout_q <= '0;
      issued_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      issued_q  <= issued_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (fetch_go) begin
          if (mem.mem_ready)    state_d = StDecode;
          else if (timeout_hit) state_d = StFault;
        end
      end
      StDecode: state_d = (cls == ClsIll) ? StFault : StExec;
      StExec: begin
        case (cls)
          ClsLw, ClsSw: state_d = StMem;
          ClsBr:        state_d = StFetch;
          default:      state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem.mem_ready)    state_d = (cls == ClsLw) ? StWb : StFetch;
        else if (timeout_hit) state_d = StFault;
      end
      StWb:    state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase
  end

  // Next values for IR, counters, timeout and issue latch
  always_comb begin
    ir_d      = ir_we ? mem.mem_rdata : ir_q;
    instret_d = retire ? instret_q + XLEN'(1) : instret_q;
    cycles_d  = cycles_q + XLEN'(1);
    // Any state change out of a waiting state is either ready or fault, both clear it
    timeout_d = (waiting && !timeout_hit) ? timeout_q + ToW'(1) : '0;
    issued_d  = (state_q == StFetch) && fetch_go && !mem.mem_ready && !timeout_hit;
  end

  // Decoded datapath controls, forced to zero while reset is asserted
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PcAlu;
    oldpc_we     = 1'b0;
    ab_we        = 1'b0;
    alu_src_a    = SrcAReg;
    alu_src_b    = SrcBReg;
    alu_ctrl     = AluAdd;
    imm_src      = ImmI;
    result_src   = ResAlu;
    reg_write    = 1'b0;
    retire       = 1'b0;
    fault        = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem.mem_req = fetch_go;
          if (fetch_go && mem.mem_ready) begin
            ir_we     = 1'b1;
            oldpc_we  = 1'b1;
            pc_we     = 1'b1;
            alu_src_a = SrcAPc;
            alu_src_b = SrcBFour;
          end
        end
        StDecode: begin
          ab_we   = 1'b1;
          imm_src = imm_sel(cls);
        end
        StExec: begin
          imm_src   = imm_sel(cls);
          alu_src_b = SrcBImm;
          case (cls)
            ClsR: begin
              alu_src_b = SrcBReg;
              alu_ctrl  = alu_op(ir_q, 1'b1);
            end
            ClsI: alu_ctrl = alu_op(ir_q, 1'b0);
            ClsBr: begin
              alu_src_a = SrcAOldPc;
              // f3=000 beq takes on eq, f3=001 bne takes on !eq
              pc_we     = eq ^ ir_q[12];
              pc_src    = (eq ^ ir_q[12]) ? PcTarget : PcAlu;
              retire    = 1'b1;
            end
            ClsJal: begin
              alu_src_a = SrcAOldPc;
              pc_we     = 1'b1;
              pc_src    = PcTarget;
            end
            ClsJalr: begin
              pc_we  = 1'b1;
              pc_src = PcJalr;
            end
            ClsLui:  alu_ctrl = AluPassB;
            default: alu_ctrl = AluAdd;
          endcase
        end
        StMem: begin
          imm_src      = imm_sel(cls);
          mem.mem_req  = 1'b1;
          mem.addr_sel = 1'b1;
          mem.mem_we   = (cls == ClsSw);
          retire       = (cls == ClsSw) && mem.mem_ready;
        end
        StWb: begin
          imm_src    = imm_sel(cls);
          reg_write  = 1'b1;
          retire     = 1'b1;
          if (cls == ClsLw)                        result_src = ResMem;
          else if (cls == ClsJal || cls == ClsJalr) result_src = ResPc4;
          else                                     result_src = ResAlu;
        end
        StFault: fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

  assign ir      = ir_q;
  assign instret = instret_q;
  assign cycles  = cycles_q;
endmodule
